// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the fetch stage and the pipeline registers that
//   consume its outputs: the data/address width, the word type, the HALT/RUN
//   state encoding and a wrapping increment helper.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  // Width of instruction words and instruction addresses.
  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  // Run/halt state of the front end.
  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Address increment, wrapping from all-ones back to zero.
  function automatic word_t inc_wrap(input word_t a);
    return a + word_t'(1);
  endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. It issues addresses to a synchronous-read
//   instruction memory (one cycle of read latency) and presents the returned
//   word together with its address to the decode stage.
//
//   A two-state controller (HALT/RUN) gates fetching. In RUN, each cycle
//   a redirect (branch_taken), a hold (stall) or a sequential advance happens,
//   in that priority order. Leaving RUN rewinds the fetch pointer to any
//   instruction still sitting in the output register, so restarting with exec
//   refetches it instead of losing it.
//
// Ports
//   clock              in   1   rising-edge clock
//   reset              in   1   synchronous active-high reset
//   exec               in   1   run/halt toggle request
//   is_halt_commanded  in   1   forced halt (HALT instruction retired)
//   stall              in   1   hold request from hazard unit
//   branch_taken       in   1   redirect request from execute
//   branch_target      in  16   redirect address
//   imem_addr          out 16   instruction memory address
//   imem_rdata         in  16   word for the previous cycle's imem_addr
//   o_instr            out 16   fetched instruction (copy of imem_rdata)
//   o_pc               out 16   address of o_instr
//   o_pc_plus1         out 16   o_pc + 1, wrapping
//   o_valid            out  1   o_instr/o_pc hold a live instruction
//   is_halt_now        out  1   block is in HALT
//   fetch_count        out 16   instructions accepted downstream
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              is_halt_commanded,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] o_instr,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_pc_plus1,
  output logic              o_valid,
  output logic              is_halt_now,
  output logic [DATA_W-1:0] fetch_count
);

  fetch_state_e r_state;
  word_t        r_pc;           // next address to fetch
  word_t        r_pc_q;         // address of the word currently on o_instr
  logic         r_valid_q;
  word_t        r_fetch_count;

  logic         w_to_halt;      // RUN is being left this cycle
  logic         w_accept;       // decode takes the current instruction
  word_t        w_imem_addr;

  assign w_to_halt = (r_state == ST_RUN) && (exec || is_halt_commanded);

  // An instruction is consumed only when it is live, nothing holds or
  // redirects it, and the front end is not being halted under it.
  assign w_accept  = (r_state == ST_RUN) && !w_to_halt && r_valid_q &&
                     !stall && !branch_taken;

  // While stalled, re-read the address already on o_pc so the memory keeps
  // returning the same word; o_instr then stays paired with o_pc for any
  // stall length. A redirect overrides the stall and issues r_pc instead.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    w_imem_addr = r_pc;
    if ((r_state == ST_RUN) && stall && !branch_taken) begin
      w_imem_addr = r_pc_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_HALT;
      r_pc          <= '0;
      r_pc_q        <= '0;
      r_valid_q     <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_count <= inc_wrap(r_fetch_count);
      end

      unique case (r_state)
        ST_HALT: begin
          // Addresses are frozen while halted; stall and redirects are moot.
          r_valid_q <= 1'b0;
          if (exec) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_to_halt) begin
            r_state   <= ST_HALT;
            r_valid_q <= 1'b0;
            // Rewind so the unconsumed instruction is fetched again on restart.
            if (r_valid_q) begin
              r_pc <= r_pc_q;
            end
          end else if (branch_taken) begin
            // The word arriving next cycle is from the wrong path; squash it.
            r_pc      <= branch_target;
            r_valid_q <= 1'b0;
          end else if (!stall) begin
            r_pc      <= inc_wrap(r_pc);
            r_pc_q    <= r_pc;
            r_valid_q <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_addr   = w_imem_addr;
  assign o_instr     = imem_rdata;
  assign o_pc        = r_pc_q;
  assign o_pc_plus1  = inc_wrap(r_pc_q);
  assign o_valid     = r_valid_q;
  assign is_halt_now = (r_state == ST_HALT);
  assign fetch_count = r_fetch_count;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. The instruction memory model returns
//   each address as its own data word with one cycle of latency. Expected
//   o_pc values are queued when a scenario's stimulus is driven and popped as
//   valid, unstalled instructions appear on the outputs.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exec = 1'b0;
  logic        is_halt_commanded = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic [15:0] o_pc_plus1;
  logic        o_valid;
  logic        is_halt_now;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .exec              (exec),
    .is_halt_commanded (is_halt_commanded),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .o_instr           (o_instr),
    .o_pc              (o_pc),
    .o_pc_plus1        (o_pc_plus1),
    .o_valid           (o_valid),
    .is_halt_now       (is_halt_now),
    .fetch_count       (fetch_count)
  );

  initial forever #5 clock = ~clock;

  // Synchronous-read memory whose content at every address is the address.
  always @(posedge clock) imem_rdata <= imem_addr;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Step cycles, comparing each valid unstalled output against the queue
  // head. Returns after the last expected entry is seen; n reports the number
  // of cycles stepped.
  task automatic drain(input int budget, output int n);
    logic [15:0] e;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
      if (o_valid && !stall) begin
        e = exp_q.pop_front();
        total++;
        if (o_pc !== e) begin
          bad++;
          $display("FAIL drain_pc: got %h want %h", o_pc, e);
        end
        total++;
        if (o_instr !== e) begin
          bad++;
          $display("FAIL drain_instr: got %h want %h", o_instr, e);
        end
        total++;
        if (o_pc_plus1 !== 16'(e + 16'd1)) begin
          bad++;
          $display("FAIL drain_pc_plus1: got %h want %h", o_pc_plus1, 16'(e + 16'd1));
        end
      end
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (is_halt_now !== 1'b1 || o_valid !== 1'b0 || imem_addr !== 16'h0000 ||
        o_pc !== 16'h0000 || o_pc_plus1 !== 16'h0001 || fetch_count !== 16'h0000) begin
      bad++;
      $display("FAIL %s: got halt=%b valid=%b addr=%h pc=%h pc1=%h cnt=%h want 1 0 0000 0000 0001 0000",
               tag, is_halt_now, o_valid, imem_addr, o_pc, o_pc_plus1, fetch_count);
    end
  endtask

  task automatic test_reset();
    // Every other input active: reset must still win.
    reset = 1'b1; exec = 1'b1; is_halt_commanded = 1'b1;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234;
    tick();
    tick();
    check_reset_outputs("reset_state");
    reset = 1'b0; exec = 1'b0; is_halt_commanded = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    tick();
    total++;
    if (is_halt_now !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_halt: got halt=%b valid=%b want 1 0", is_halt_now, o_valid);
    end
  endtask

  task automatic test_run_start();
    int n;
    exec = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    tick();
    exec = 1'b0;
    total++;
    if (is_halt_now !== 1'b0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL run_first_cycle: got halt=%b valid=%b want 0 0", is_halt_now, o_valid);
    end
    drain(10, n);
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL run_latency: got %0d cycles want 3", n);
    end
    total++;
    if (fetch_count !== 16'd2) begin
      bad++;
      $display("FAIL run_count: got %h want 0002", fetch_count);
    end
  endtask

  task automatic test_stall();
    int n;
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0005);
    drain(10, n);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (o_pc !== 16'h0005 || o_instr !== 16'h0005 || o_valid !== 1'b1 ||
          imem_addr !== 16'h0005 || fetch_count !== 16'd5) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h instr=%h valid=%b addr=%h cnt=%h want 0005 0005 1 0005 0005",
                 i, o_pc, o_instr, o_valid, imem_addr, fetch_count);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (o_pc !== 16'h0006 || o_instr !== 16'h0006 || o_valid !== 1'b1 || fetch_count !== 16'd6) begin
      bad++;
      $display("FAIL stall_release: got pc=%h instr=%h valid=%b cnt=%h want 0006 0006 1 0006",
               o_pc, o_instr, o_valid, fetch_count);
    end
  endtask

  task automatic test_branch();
    int n;
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0041);
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    total++;
    if (o_valid !== 1'b0 || fetch_count !== 16'd6) begin
      bad++;
      $display("FAIL branch_bubble: got valid=%b cnt=%h want 0 0006", o_valid, fetch_count);
    end
    drain(10, n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL branch_penalty: got %0d cycles want 2", n);
    end
  endtask

  task automatic test_halt_resume();
    int n;
    branch_taken = 1'b1; branch_target = 16'h0010;
    tick();
    branch_taken = 1'b0;
    tick();
    total++;
    if (o_pc !== 16'h0010 || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL halt_setup: got pc=%h valid=%b want 0010 1", o_pc, o_valid);
    end
    is_halt_commanded = 1'b1;
    tick();
    is_halt_commanded = 1'b0;
    total++;
    if (is_halt_now !== 1'b1 || o_valid !== 1'b0 || imem_addr !== 16'h0010 || fetch_count !== 16'd7) begin
      bad++;
      $display("FAIL halt_enter: got halt=%b valid=%b addr=%h cnt=%h want 1 0 0010 0007",
               is_halt_now, o_valid, imem_addr, fetch_count);
    end
    // Stall and redirect are ignored while halted.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0099;
    tick();
    total++;
    if (is_halt_now !== 1'b1 || o_valid !== 1'b0 || imem_addr !== 16'h0010 || o_pc !== 16'h0010) begin
      bad++;
      $display("FAIL halt_ignore: got halt=%b valid=%b addr=%h pc=%h want 1 0 0010 0010",
               is_halt_now, o_valid, imem_addr, o_pc);
    end
    stall = 1'b0; branch_taken = 1'b0;
    // exec beats a simultaneous halt command when leaving HALT.
    exec = 1'b1; is_halt_commanded = 1'b1;
    exp_q.push_back(16'h0010);
    tick();
    exec = 1'b0; is_halt_commanded = 1'b0;
    total++;
    if (is_halt_now !== 1'b0) begin
      bad++;
      $display("FAIL resume_exec_wins: got halt=%b want 0", is_halt_now);
    end
    drain(10, n);
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL resume_latency: got %0d cycles want 1", n);
    end
  endtask

  task automatic test_wrap_and_reset();
    int n;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    tick();
    branch_taken = 1'b0;
    drain(10, n);
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL wrap_sequence: got %0d cycles want 2", n);
    end
    // Reset while running, with every other request active.
    reset = 1'b1; exec = 1'b1; is_halt_commanded = 1'b1;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234;
    tick();
    check_reset_outputs("reset_mid_run");
    reset = 1'b0; exec = 1'b0; is_halt_commanded = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    tick();
  endtask

  task automatic test_back_to_back_exec();
    // exec in the first RUN cycle halts again; nothing was live, so no rewind.
    exec = 1'b1;
    tick();
    tick();
    exec = 1'b0;
    total++;
    if (is_halt_now !== 1'b1 || o_valid !== 1'b0 || imem_addr !== 16'h0000 || fetch_count !== 16'd0) begin
      bad++;
      $display("FAIL exec_toggle: got halt=%b valid=%b addr=%h cnt=%h want 1 0 0000 0000",
               is_halt_now, o_valid, imem_addr, fetch_count);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_run_start();
    test_stall();
    test_branch();
    test_halt_resume();
    test_wrap_and_reset();
    test_back_to_back_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use reset reset, synchronous, active-high; clock clock.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clock  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  exec  in  1  run/halt toggle request
  is_halt_commanded  in  1  forced halt (HALT instruction retired)
  stall  in  1  hold request from hazard unit
  branch_taken  in  1  redirect request from execute
  branch_target  in  16  redirect address
  imem_addr  out  16  instruction memory address (synchronous read, 1-cycle latency)
  imem_rdata  in  16  instruction word for previous cycle's imem_addr
  o_instr  out  16  fetched instruction, combinational copy of imem_rdata
  o_pc  out  16  address of o_instr
  o_pc_plus1  out  16  o_pc + 1, modulo 2^16
  o_valid  out  1  o_instr/o_pc are a live instruction
  is_halt_now  out  1  block is in HALT
  fetch_count  out  16  instructions accepted downstream

Function
REQ-003 State machine SHALL have two states: HALT, RUN; is_halt_now = 1 exactly in HALT.
REQ-004 HALT: exec=1 -> RUN (exec wins over simultaneous is_halt_commanded); otherwise stay.
REQ-005 RUN: exec=1 or is_halt_commanded=1 -> HALT.
REQ-006 Internal registers: pc (next address to fetch), pc_q (drives o_pc), valid_q (drives o_valid).
REQ-007 RUN, no state change, priority: branch_taken, then stall, then advance.
REQ-008 branch_taken: pc <= branch_target, valid_q <= 0, pc_q held; stall ignored that cycle.
REQ-009 stall (no branch): pc, pc_q, valid_q held.
REQ-010 Advance: pc <= pc+1 (FFFF wraps to 0000), pc_q <= pc, valid_q <= 1.
REQ-011 imem_addr SHALL equal pc_q when state=RUN and stall=1 and branch_taken=0, otherwise pc, so o_instr stays matched to o_pc across any stall length.
REQ-012 RUN->HALT transition: valid_q <= 0; pc <= pc_q if valid_q=1 (rewind to refetch unconsumed instruction), else pc held.
REQ-013 In HALT: pc, pc_q held, valid_q=0; stall and branch_taken ignored.
REQ-014 HALT->RUN: first RUN cycle issues pc, o_valid rises one cycle later with o_pc = that pc.
REQ-015 Branch penalty SHALL be exactly one o_valid=0 cycle; next valid o_pc = branch_target.
REQ-016 fetch_count SHALL increment by 1 (wrapping) each cycle with o_valid=1, stall=0, branch_taken=0, state=RUN and no transition to HALT.
REQ-017 o_pc_plus1 SHALL be combinational from pc_q.

Reset
REQ-018 reset SHALL set state=HALT, pc=0000, pc_q=0000, valid_q=0, fetch_count=0000; hence is_halt_now=1, o_valid=0, imem_addr=0000.
REQ-019 reset SHALL take priority over exec, is_halt_commanded, stall, branch_taken in the same cycle, including mid-RUN.

Structure
REQ-020 Shared package SHALL hold the 16-bit data/address width constant and the HALT/RUN state encoding, reused by the pipeline registers.
REQ-021 No sub-module is required; single flat module.

Verification
REQ-022 Reset, then exec pulse; imem returns addr as data -> o_valid rises 2 cycles after exec, o_pc sequence 0000,0001,0002, o_instr==o_pc each valid cycle.
REQ-023 RUN at o_pc=0005, stall held 3 cycles -> o_pc=0005, o_instr=0005, o_valid=1 throughout; after release, o_pc=0006 next cycle; fetch_count increments once for 0005.
REQ-024 branch_taken with branch_target=0040 and stall=1 same cycle -> one o_valid=0 cycle, then o_pc=0040, 0041.
REQ-025 is_halt_commanded at o_pc=0010 valid -> is_halt_now=1, o_valid=0; exec later -> first valid o_pc=0010.
REQ-026 pc at FFFF advancing -> o_pc FFFF then 0000, o_pc_plus1 0000 then 0001; reset mid-RUN -> HALT, all outputs per REQ-018 next cycle.
